execute_muldiv_unit: RTL

- Iterative multiply/divide unit in the Execute stage, fed by the Decode/Execute pipeline register outputs (src_a_E, src_b_E, funct_E, Arith_u_E decoded into op).
- Owns the architectural HI/LO registers. Executes MULT/MULTU (fixed latency) and DIV/DIVU (radix-2 restoring, 32 iterations), plus MTHI/MTLO.
- Drives busy to the hazard unit, which stalls any following mul/div/MFHI/MFLO until the operation completes.

---
 rtl/execute_muldiv_if.sv | 26 ++
 rtl/execute_muldiv_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_if.sv
// Execute-stage mul/div handshake bundle.
// master: Execute stage (op_valid, op, src_a, src_b, flush); slave: mul/div unit
// (busy, done, hi, lo). Clock and reset are plain ports on the unit itself.
interface execute_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/execute_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Ports: clk, rst_n (sync, active-low), bus (slave): op_valid/op/src_a/src_b/flush in,
// busy/done/hi/lo out. MULT/MULTU commit after MUL_CYCLES, DIV/DIVU after 33, MT* at once.
module execute_muldiv_unit #(
  parameter int MUL_CYCLES = 3,
  parameter int WIDTH      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  execute_muldiv_if.slave bus
);
  localparam int W = WIDTH;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t         state, state_n;
  logic [4:0]     cnt;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem, dvs;
  logic           q_neg, r_neg;
  logic [W-1:0]   hi_q, lo_q;
  logic           busy_q, done_q;

  logic           accept, commit;
  logic           is_signed, a_neg, b_neg;
  logic [W-1:0]   abs_a, abs_b;
  logic [2*W-1:0] ext_a, ext_b, prod_full;
  logic [W:0]     shifted;
  logic [W-1:0]   rem_n, quo_n;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Even opcodes (MULT, DIV) are the signed flavours.
  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.src_a[W-1];
  assign b_neg     = is_signed & bus.src_b[W-1];
  assign abs_a     = a_neg ? -bus.src_a : bus.src_a;
  assign abs_b     = b_neg ? -bus.src_b : bus.src_b;
  assign ext_a     = {{W{a_neg}}, bus.src_a};
  assign ext_b     = {{W{b_neg}}, bus.src_b};
  // Low 2W bits of the extended product are the exact signed/unsigned product.
  assign prod_full = ext_a * ext_b;

  assign accept = (state == S_IDLE) && bus.op_valid && !bus.flush;

  // Restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    shifted = {rem, quo[W-1]};
    rem_n   = shifted[W-1:0];
    quo_n   = {quo[W-2:0], 1'b0};
    if (shifted >= {1'b0, dvs}) begin
      rem_n = W'(shifted - {1'b0, dvs});
      quo_n = {quo[W-2:0], 1'b1};
    end
  end

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.op)
            OP_MULT, OP_MULTU: state_n = S_MUL;
            OP_DIV, OP_DIVU:   state_n = (bus.src_b == '0) ? S_FIX : S_DIV;
            default:           state_n = S_IDLE;
          endcase
        end
      end
      S_MUL: begin
        if (cnt == 5'd0) begin
          commit  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_DIV: begin
        if (cnt == 5'd0) state_n = S_FIX;
      end
      S_FIX: begin
        commit  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // A flush aborts any in-flight op, including one on its commit edge.
    if (state != S_IDLE && bus.flush) begin
      state_n = S_IDLE;
      commit  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      prod   <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n != S_IDLE);
      done_q <= commit;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                prod <= prod_full;
                cnt  <= 5'(MUL_CYCLES - 1);
              end
              OP_DIV, OP_DIVU: begin
                if (bus.src_b == '0) begin
                  // Divide by zero: all-ones quotient, dividend as remainder.
                  quo   <= '1;
                  rem   <= bus.src_a;
                  q_neg <= 1'b0;
                  r_neg <= 1'b0;
                end else begin
                  quo   <= abs_a;
                  rem   <= '0;
                  dvs   <= abs_b;
                  q_neg <= a_neg ^ b_neg;
                  r_neg <= a_neg;
                  cnt   <= 5'(W - 1);
                end
              end
              OP_MTHI: hi_q <= bus.src_a;
              OP_MTLO: lo_q <= bus.src_a;
              default: ;
            endcase
          end
        end
        S_MUL: cnt <= cnt - 5'd1;
        S_DIV: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt - 5'd1;
        end
        default: ;
      endcase
      if (commit) begin
        if (state == S_MUL) begin
          hi_q <= prod[2*W-1:W];
          lo_q <= prod[W-1:0];
        end else begin
          lo_q <= q_neg ? -quo : quo;
          hi_q <= r_neg ? -rem : rem;
        end
      end
    end
  end
endmodule
